opcode_scheduler: RTL

//  Line-commit scheduler between the parser and the CPU execute stage.
//  - Buffers parsed (opcode, data) entries in a circular FIFO.
//  - Releases entries to the CPU only after the whole input line has parsed cleanly.
//  - A parse error or overflow discards every entry of the current line.
//  - Drains committed entries to the CPU over a valid/ready handshake, one per cycle.
//

---
 rtl/opcode_scheduler_if.sv | 43 ++++
 rtl/opcode_scheduler.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/opcode_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : opcode_scheduler_if
//  Description : Parser-side and CPU-side bus bundle for opcode_scheduler.
//                The master modport is the environment (parser + CPU); the
//                slave modport is the scheduler itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface opcode_scheduler_if #(
    parameter int DATA   = 32,
    parameter int OPCODE = 16,
    parameter int DEPTH  = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              i_p_valid;
    logic [OPCODE-1:0] i_p_opcode;
    logic [DATA-1:0]   i_p_data;
    logic              i_p_err;
    logic              i_p_eol;
    logic              o_p_stall;
    logic              o_cpu_valid;
    logic [OPCODE-1:0] o_cpu_opcode;
    logic [DATA-1:0]   o_cpu_data;
    logic              i_cpu_ready;
    logic              o_line_done;
    logic              o_line_err;
    logic [1:0]        o_err_code;
    logic [CW-1:0]     o_count;

    modport master (
        output i_p_valid, i_p_opcode, i_p_data, i_p_err, i_p_eol, i_cpu_ready,
        input  o_p_stall, o_cpu_valid, o_cpu_opcode, o_cpu_data,
               o_line_done, o_line_err, o_err_code, o_count
    );

    modport slave (
        input  i_p_valid, i_p_opcode, i_p_data, i_p_err, i_p_eol, i_cpu_ready,
        output o_p_stall, o_cpu_valid, o_cpu_opcode, o_cpu_data,
               o_line_done, o_line_err, o_err_code, o_count
    );
endinterface
`default_nettype wire

// File: rtl/opcode_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : opcode_scheduler
//  Description : Line-commit FIFO between parser and CPU execute stage.
//                Entries of a line are written speculatively and only become
//                visible to the CPU once the line ends cleanly; an error or
//                overflow rolls the write pointer back to the last commit.
//  Revision    : 1.0  initial release
// ============================================================================
module opcode_scheduler #(
    parameter int DATA   = 32,
    parameter int OPCODE = 16,
    parameter int DEPTH  = 16
) (
    input  wire logic         i_clk,
    input  wire logic         i_rst,
    input  wire logic         i_en,
    opcode_scheduler_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW-1:0] PTR_DEPTH = PW'(DEPTH);
    localparam logic [1:0]    ERR_NONE  = 2'd0;
    localparam logic [1:0]    ERR_PARSE = 2'd1;
    localparam logic [1:0]    ERR_OVF   = 2'd2;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        DISCARD = 1'b1
    } state_t;

    logic [OPCODE-1:0] mem_opcode [DEPTH];
    logic [DATA-1:0]   mem_data   [DEPTH];

    state_t            state, state_nx;
    logic [PW-1:0]     wr_ptr, wr_ptr_nx;
    logic [PW-1:0]     cm_ptr, cm_ptr_nx;
    logic [PW-1:0]     rd_ptr;
    logic [1:0]        err_code, err_code_nx;
    logic              line_done, line_done_nx;
    logic              line_err, line_err_nx;
    logic              wr_en;
    logic              full, empty, load;
    logic              cpu_valid;
    logic [OPCODE-1:0] cpu_opcode;
    logic [DATA-1:0]   cpu_data;

    // Full/empty come from registered pointers only, so a same-cycle CPU read
    // never makes room for a write that arrives while full.
    assign full  = (wr_ptr - rd_ptr) == PTR_DEPTH;
    assign empty = (rd_ptr == cm_ptr);
    assign load  = !empty && (!cpu_valid || bus.i_cpu_ready);

    // Line collection: speculative writes, commit on eol, rollback on error/overflow.
    always_comb begin
        state_nx     = state;
        wr_ptr_nx    = wr_ptr;
        cm_ptr_nx    = cm_ptr;
        err_code_nx  = err_code;
        line_done_nx = 1'b0;
        line_err_nx  = 1'b0;
        wr_en        = 1'b0;
        case (state)
            COLLECT: begin
                if (bus.i_p_err || (bus.i_p_valid && full)) begin
                    wr_ptr_nx   = cm_ptr;
                    err_code_nx = bus.i_p_err ? ERR_PARSE : ERR_OVF;
                    // An eol in the same cycle closes the failed line at once.
                    if (bus.i_p_eol) begin
                        line_err_nx = 1'b1;
                    end else begin
                        state_nx = DISCARD;
                    end
                end else begin
                    if (bus.i_p_valid) begin
                        wr_en     = 1'b1;
                        wr_ptr_nx = wr_ptr + PTR_ONE;
                    end
                    if (bus.i_p_eol) begin
                        cm_ptr_nx    = wr_ptr_nx;
                        line_done_nx = 1'b1;
                        err_code_nx  = ERR_NONE;
                    end
                end
            end
            default: begin
                if (bus.i_p_eol) begin
                    line_err_nx = 1'b1;
                    state_nx    = COLLECT;
                end
            end
        endcase
    end

    // Collection state, pointers and error code register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= COLLECT;
            wr_ptr   <= '0;
            cm_ptr   <= '0;
            err_code <= ERR_NONE;
        end else if (i_en) begin
            state    <= state_nx;
            wr_ptr   <= wr_ptr_nx;
            cm_ptr   <= cm_ptr_nx;
            err_code <= err_code_nx;
        end
    end

    // Status pulses last exactly one enabled cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            line_done <= 1'b0;
            line_err  <= 1'b0;
        end else begin
            line_done <= i_en && line_done_nx;
            line_err  <= i_en && line_err_nx;
        end
    end

    // Entry storage; never reset, contents are qualified by the pointers.
    always_ff @(posedge i_clk) begin
        if (i_en && wr_en) begin
            mem_opcode[wr_ptr[AW-1:0]] <= bus.i_p_opcode;
            mem_data[wr_ptr[AW-1:0]]   <= bus.i_p_data;
        end
    end

    // Show-ahead output register: refill whenever empty or being accepted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr     <= '0;
            cpu_valid  <= 1'b0;
            cpu_opcode <= '0;
            cpu_data   <= '0;
        end else if (i_en) begin
            if (load) begin
                cpu_opcode <= mem_opcode[rd_ptr[AW-1:0]];
                cpu_data   <= mem_data[rd_ptr[AW-1:0]];
                cpu_valid  <= 1'b1;
                rd_ptr     <= rd_ptr + PTR_ONE;
            end else if (cpu_valid && bus.i_cpu_ready) begin
                cpu_valid <= 1'b0;
            end
        end
    end

    assign bus.o_p_stall    = full;
    assign bus.o_cpu_valid  = cpu_valid;
    assign bus.o_cpu_opcode = cpu_opcode;
    assign bus.o_cpu_data   = cpu_data;
    assign bus.o_line_done  = line_done;
    assign bus.o_line_err   = line_err;
    assign bus.o_err_code   = err_code;
    assign bus.o_count      = wr_ptr - rd_ptr;

endmodule
`default_nettype wire
